// File: rtl/fm_parity_chk.sv
// FM parity checker with sticky first-error capture and an EBUS diagnostic readout.
// A two-stage pipeline checks every valid read; the diag FSM returns a frozen snapshot of the error state.
module fm_parity_chk #(
  parameter bit PAR_ODD = 1'b1
) (
  input  logic        clk_apr_h,
  input  logic        apr_reset_h,
  input  logic [5:0]  edp_fm_parity_h,
  input  logic        fm_par_bit_h,
  input  logic [3:0]  apr_fm_adr_h,
  input  logic [2:0]  apr_fm_block_h,
  input  logic        fm_rd_valid_h,
  input  logic        con_fm_write_l,
  input  logic        con_fm_par_chk_en_h,
  input  logic        apr_fm_par_clr_h,
  input  logic        diag_read_fm_par_h,
  input  logic        diag_rdclr_h,
  output logic        fm_par_err_h,
  output logic        fm_par_overrun_h,
  output logic [0:35] ebus_d_h,
  output logic        ebus_d_en_h,
  output logic        ebus_xfer_h
);

  typedef enum logic [1:0] {IDLE, SETUP, XFER} diag_state_e;

  logic        valid_s1_q, en_s1_q, pbit_s1_q;
  logic [5:0]  par_s1_q;
  logic [3:0]  adr_s1_q;
  logic [2:0]  blk_s1_q;
  logic        err_q, err_d, ovr_q, ovr_d;
  logic [13:0] cap_q, cap_d;
  diag_state_e state_q, state_d;
  logic        req_q, armed_q, rdclr_q;
  logic [0:15] snap_q, snap_word;
  logic        sample, bad, err_hit, req_rise, clear;

  assign sample = fm_rd_valid_h & con_fm_write_l;

  // NOTE: sequential state always uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk_apr_h) begin
    if (apr_reset_h) begin
      valid_s1_q <= 1'b0;
      en_s1_q    <= 1'b0;
      pbit_s1_q  <= 1'b0;
      par_s1_q   <= '0;
      adr_s1_q   <= '0;
      blk_s1_q   <= '0;
    end else begin
      valid_s1_q <= sample;
      if (sample) begin
        en_s1_q   <= con_fm_par_chk_en_h;
        pbit_s1_q <= fm_par_bit_h;
        par_s1_q  <= edp_fm_parity_h;
        adr_s1_q  <= apr_fm_adr_h;
        blk_s1_q  <= apr_fm_block_h;
      end
    end
  end

  assign bad     = ((^par_s1_q) ^ pbit_s1_q) != PAR_ODD;
  assign err_hit = valid_s1_q & en_s1_q & bad;
  assign clear   = apr_fm_par_clr_h
                 | ((state_q == XFER) & ~diag_read_fm_par_h & rdclr_q);

  // A new error in the clearing cycle wins over the clear and becomes the first error.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    err_d = err_q;
    ovr_d = ovr_q;
    cap_d = cap_q;
    if (err_hit && (clear || !err_q)) begin
      err_d = 1'b1;
      ovr_d = 1'b0;
      cap_d = {blk_s1_q, adr_s1_q, par_s1_q, pbit_s1_q};
    end else if (err_hit) begin
      ovr_d = 1'b1;
    end else if (clear) begin
      err_d = 1'b0;
      ovr_d = 1'b0;
      cap_d = '0;
    end
  end

  always_ff @(posedge clk_apr_h) begin
    if (apr_reset_h) begin
      err_q <= 1'b0;
      ovr_q <= 1'b0;
      cap_q <= '0;
    end else begin
      err_q <= err_d;
      ovr_q <= ovr_d;
      cap_q <= cap_d;
    end
  end

  // armed_q blocks a request left high across reset until it has been seen low.
  assign req_rise = diag_read_fm_par_h & ~req_q & armed_q;

  always_comb begin
    snap_word = '0;
    snap_word[0]   = err_q;
    snap_word[1]   = ovr_q;
    snap_word[2:4] = cap_q[13:11];
    snap_word[5:8] = cap_q[10:7];
    for (int i = 0; i < 6; i++) snap_word[9+i] = cap_q[1+i];
    snap_word[15]  = cap_q[0];
  end

  always_ff @(posedge clk_apr_h) begin
    if (apr_reset_h) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      armed_q <= 1'b0;
      rdclr_q <= 1'b0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= diag_read_fm_par_h;
      if (!diag_read_fm_par_h) armed_q <= 1'b1;
      if (state_q == IDLE && req_rise) begin
        snap_q  <= snap_word;
        rdclr_q <= diag_rdclr_h;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_rise) state_d = SETUP;
      SETUP:   state_d = XFER;
      XFER:    if (!diag_read_fm_par_h) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ebus_d_en_h = (state_q != IDLE);
    ebus_xfer_h = (state_q == XFER);
    ebus_d_h    = ebus_d_en_h ? {snap_q, 20'b0} : '0;
  end

  assign fm_par_err_h     = err_q;
  assign fm_par_overrun_h = ovr_q;

endmodule

// File: tb/tb_fm_parity_chk.sv
// Self-checking bench for fm_parity_chk: vector table, back-to-back stream scoreboard,
// and hand-written diag handshake, clear-collision and reset sequences.
module tb_fm_parity_chk;

  logic        clk_apr_h = 1'b0;
  logic        apr_reset_h;
  logic [5:0]  edp_fm_parity_h;
  logic        fm_par_bit_h;
  logic [3:0]  apr_fm_adr_h;
  logic [2:0]  apr_fm_block_h;
  logic        fm_rd_valid_h;
  logic        con_fm_write_l;
  logic        con_fm_par_chk_en_h;
  logic        apr_fm_par_clr_h;
  logic        diag_read_fm_par_h;
  logic        diag_rdclr_h;
  logic        fm_par_err_h;
  logic        fm_par_overrun_h;
  logic [0:35] ebus_d_h;
  logic        ebus_d_en_h;
  logic        ebus_xfer_h;

  fm_parity_chk #(.PAR_ODD(1'b1)) dut (
    .clk_apr_h(clk_apr_h), .apr_reset_h(apr_reset_h),
    .edp_fm_parity_h(edp_fm_parity_h), .fm_par_bit_h(fm_par_bit_h),
    .apr_fm_adr_h(apr_fm_adr_h), .apr_fm_block_h(apr_fm_block_h),
    .fm_rd_valid_h(fm_rd_valid_h), .con_fm_write_l(con_fm_write_l),
    .con_fm_par_chk_en_h(con_fm_par_chk_en_h), .apr_fm_par_clr_h(apr_fm_par_clr_h),
    .diag_read_fm_par_h(diag_read_fm_par_h), .diag_rdclr_h(diag_rdclr_h),
    .fm_par_err_h(fm_par_err_h), .fm_par_overrun_h(fm_par_overrun_h),
    .ebus_d_h(ebus_d_h), .ebus_d_en_h(ebus_d_en_h), .ebus_xfer_h(ebus_xfer_h)
  );

  always #5 clk_apr_h = ~clk_apr_h;

  typedef struct {
    logic [5:0] par;
    logic       pb;
    logic       en;
    logic       wl;
    logic       exp_err;
  } vec_t;

  vec_t vecs[8];
  vec_t strm[6];
  logic sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_apr_h);
    #1;
  endtask

  function automatic logic [0:35] mk_word(input logic err, input logic ovr, input logic [2:0] blk,
                                          input logic [3:0] adr, input logic [5:0] syn, input logic pb);
    logic [0:35] w;
    w = '0;
    w[0] = err;
    w[1] = ovr;
    w[2:4] = blk;
    w[5:8] = adr;
    for (int i = 0; i < 6; i++) w[9+i] = syn[i];
    w[15] = pb;
    return w;
  endfunction

  task automatic do_clr();
    apr_fm_par_clr_h = 1'b1;
    tick();
    apr_fm_par_clr_h = 1'b0;
  endtask

  // Drives one read in the current cycle; returns in the following cycle.
  task automatic read_cycle(input logic [5:0] par, input logic pb, input logic [3:0] adr,
                            input logic [2:0] blk, input logic en, input logic wl);
    edp_fm_parity_h = par; fm_par_bit_h = pb; apr_fm_adr_h = adr; apr_fm_block_h = blk;
    con_fm_par_chk_en_h = en; con_fm_write_l = wl; fm_rd_valid_h = 1'b1;
    tick();
    fm_rd_valid_h = 1'b0; con_fm_write_l = 1'b1; con_fm_par_chk_en_h = 1'b1;
  endtask

  initial begin
    logic        exp_bit, err_m, ovr_m;
    logic [0:35] w;

    vecs[0] = '{6'b000001, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{6'b000000, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[2] = '{6'b000000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{6'b111111, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{6'b110100, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{6'b000000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{6'b000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{6'b101010, 1'b1, 1'b1, 1'b1, 1'b1};
    strm[0] = '{6'b000001, 1'b0, 1'b1, 1'b1, 1'b0};
    strm[1] = '{6'b100000, 1'b1, 1'b1, 1'b1, 1'b1};
    strm[2] = '{6'b011100, 1'b0, 1'b1, 1'b1, 1'b0};
    strm[3] = '{6'b000000, 1'b0, 1'b1, 1'b1, 1'b1};
    strm[4] = '{6'b111110, 1'b0, 1'b1, 1'b1, 1'b0};
    strm[5] = '{6'b000000, 1'b1, 1'b1, 1'b1, 1'b0};

    apr_reset_h = 1'b1; edp_fm_parity_h = '0; fm_par_bit_h = 1'b0; apr_fm_adr_h = '0;
    apr_fm_block_h = '0; fm_rd_valid_h = 1'b0; con_fm_write_l = 1'b1;
    con_fm_par_chk_en_h = 1'b1; apr_fm_par_clr_h = 1'b0; diag_read_fm_par_h = 1'b0;
    diag_rdclr_h = 1'b0;
    tick(); tick();
    apr_reset_h = 1'b0;
    check("reset_err", fm_par_err_h, 1'b0);
    check("reset_ovr", fm_par_overrun_h, 1'b0);
    check("reset_den", ebus_d_en_h, 1'b0);
    check("reset_xfer", ebus_xfer_h, 1'b0);
    check("reset_data", ebus_d_h, 36'h0);

    // Good parity stays clean through cycle 5.
    read_cycle(6'b000001, 1'b0, 4'h1, 3'd0, 1'b1, 1'b1);
    for (int c = 1; c <= 5; c++) begin
      check("good_hold", fm_par_err_h, 1'b0);
      tick();
    end

    // Vector table: isolated reads, expectation queued at drive, compared two cycles later.
    for (int i = 0; i < 8; i++) begin
      do_clr();
      sb.push_back(vecs[i].exp_err);
      read_cycle(vecs[i].par, vecs[i].pb, 4'(i), 3'(i), vecs[i].en, vecs[i].wl);
      tick();
      exp_bit = sb.pop_front();
      check($sformatf("vec%0d_err", i), fm_par_err_h, exp_bit);
      check($sformatf("vec%0d_ovr", i), fm_par_overrun_h, 1'b0);
    end

    // Back-to-back stream: one read per cycle, sticky model applied as results emerge.
    do_clr();
    err_m = 1'b0; ovr_m = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i >= 2) begin
        exp_bit = sb.pop_front();
        if (exp_bit) begin
          if (err_m) ovr_m = 1'b1;
          else err_m = 1'b1;
        end
        check($sformatf("strm%0d_err", i), fm_par_err_h, err_m);
        check($sformatf("strm%0d_ovr", i), fm_par_overrun_h, ovr_m);
      end
      if (i < 6) begin
        edp_fm_parity_h = strm[i].par; fm_par_bit_h = strm[i].pb;
        apr_fm_adr_h = 4'(i); fm_rd_valid_h = 1'b1;
        sb.push_back(strm[i].exp_err);
      end else begin
        fm_rd_valid_h = 1'b0;
      end
      tick();
    end

    // Single error, then suppressed and real overrun.
    do_clr();
    read_cycle(6'b000000, 1'b0, 4'hA, 3'd3, 1'b1, 1'b1);
    check("single_n1_err", fm_par_err_h, 1'b0);
    tick();
    check("single_n2_err", fm_par_err_h, 1'b1);
    check("single_n2_ovr", fm_par_overrun_h, 1'b0);
    read_cycle(6'b000000, 1'b0, 4'h5, 3'd0, 1'b1, 1'b0);
    tick();
    check("write_no_ovr", fm_par_overrun_h, 1'b0);
    read_cycle(6'b000000, 1'b0, 4'h5, 3'd0, 1'b0, 1'b1);
    tick();
    check("chkdis_no_ovr", fm_par_overrun_h, 1'b0);
    read_cycle(6'b000000, 1'b0, 4'h5, 3'd0, 1'b1, 1'b1);
    check("ovr_n1", fm_par_overrun_h, 1'b0);
    tick();
    check("ovr_n2", fm_par_overrun_h, 1'b1);

    // Diag read without clear: snapshot shows first error (adr A) plus overrun.
    w = mk_word(1'b1, 1'b1, 3'd3, 4'hA, 6'b000000, 1'b0);
    diag_rdclr_h = 1'b0; diag_read_fm_par_h = 1'b1;
    tick();
    check("rd1_setup_en", ebus_d_en_h, 1'b1);
    check("rd1_setup_xfer", ebus_xfer_h, 1'b0);
    check("rd1_setup_data", ebus_d_h, w);
    tick();
    check("rd1_xfer", ebus_xfer_h, 1'b1);
    check("rd1_xfer_data", ebus_d_h, w);
    diag_read_fm_par_h = 1'b0;
    tick();
    check("rd1_idle_en", ebus_d_en_h, 1'b0);
    check("rd1_idle_data", ebus_d_h, 36'h0);
    check("rd1_keep_err", fm_par_err_h, 1'b1);

    // Clear collides with a stage-1 error at adr 7: the error wins.
    read_cycle(6'b000011, 1'b0, 4'h7, 3'd1, 1'b1, 1'b1);
    apr_fm_par_clr_h = 1'b1;
    tick();
    apr_fm_par_clr_h = 1'b0;
    check("coll_err", fm_par_err_h, 1'b1);
    check("coll_ovr", fm_par_overrun_h, 1'b0);

    // Read-and-clear handshake, request high for five cycles (T..T+4).
    w = mk_word(1'b1, 1'b0, 3'd1, 4'h7, 6'b000011, 1'b0);
    diag_rdclr_h = 1'b1; diag_read_fm_par_h = 1'b1;
    tick();
    diag_rdclr_h = 1'b0;
    check("rc_t1_en", ebus_d_en_h, 1'b1);
    check("rc_t1_xfer", ebus_xfer_h, 1'b0);
    check("rc_t1_data", ebus_d_h, w);
    read_cycle(6'b000000, 1'b0, 4'h2, 3'd0, 1'b1, 1'b1);
    check("rc_t2_xfer", ebus_xfer_h, 1'b1);
    check("rc_t2_data", ebus_d_h, w);
    tick();
    check("rc_t3_live_ovr", fm_par_overrun_h, 1'b1);
    check("rc_t3_data", ebus_d_h, w);
    tick();
    check("rc_t4_xfer", ebus_xfer_h, 1'b1);
    tick();
    check("rc_t5_en", ebus_d_en_h, 1'b1);
    check("rc_t5_xfer", ebus_xfer_h, 1'b1);
    diag_read_fm_par_h = 1'b0;
    tick();
    check("rc_t6_en", ebus_d_en_h, 1'b0);
    check("rc_t6_xfer", ebus_xfer_h, 1'b0);
    check("rc_t6_data", ebus_d_h, 36'h0);
    check("rc_t6_err", fm_par_err_h, 1'b0);
    check("rc_t6_ovr", fm_par_overrun_h, 1'b0);

    // One-cycle request: still one XFER cycle; capture is now empty.
    diag_read_fm_par_h = 1'b1;
    tick();
    diag_read_fm_par_h = 1'b0;
    check("short_setup_en", ebus_d_en_h, 1'b1);
    check("short_cap_zero", ebus_d_h, 36'h0);
    tick();
    check("short_xfer", ebus_xfer_h, 1'b1);
    tick();
    check("short_idle_en", ebus_d_en_h, 1'b0);
    check("short_idle_xfer", ebus_xfer_h, 1'b0);

    // Reset mid-XFER with request held high.
    read_cycle(6'b000000, 1'b0, 4'h3, 3'd2, 1'b1, 1'b1);
    tick();
    diag_read_fm_par_h = 1'b1;
    tick(); tick();
    check("rst_pre_xfer", ebus_xfer_h, 1'b1);
    apr_reset_h = 1'b1;
    tick();
    apr_reset_h = 1'b0;
    check("rst_en", ebus_d_en_h, 1'b0);
    check("rst_xfer", ebus_xfer_h, 1'b0);
    check("rst_data", ebus_d_h, 36'h0);
    check("rst_err", fm_par_err_h, 1'b0);
    check("rst_ovr", fm_par_overrun_h, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rst_no_retrig", ebus_d_en_h, 1'b0);
    end
    diag_read_fm_par_h = 1'b0;
    tick();
    diag_read_fm_par_h = 1'b1;
    tick();
    check("rst_retrig_en", ebus_d_en_h, 1'b1);
    diag_read_fm_par_h = 1'b0;
    tick(); tick();
    check("rst_final_idle", ebus_d_en_h, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
